adc_frame_controller: RTL

Sequencer that sits directly behind `ADC_SPI_In` and turns its stream of 16-bit words into a coherent multi-channel ADC frame. It watches the raw SPI clock for activity. Each received word goes into the next channel slot of a shadow buffer, and the full frame is published atomically. When a word stalls mid-transfer (short packet), the controller resets the receiver to flush the stale bits, then resynchronises to channel 0. It also resynchronises to channel 0 when the gap between words exceeds the frame gap.

---
 rtl/adc_frame_controller.sv | 100 ++++++++++
 1 files changed

// File: rtl/adc_frame_controller.sv
// adc_frame_controller: gathers ADC SPI words into per-channel slots and publishes complete frames atomically.
module adc_frame_controller #(
  parameter int CHANNELS = 4,
  parameter int IDLE_CYCLES = 256,
  parameter int FRAME_GAP = 4096,
  localparam int IW = $clog2(CHANNELS),
  localparam int TW = $clog2(FRAME_GAP + 1)
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     spi_clock_in,
  input  logic [15:0]              data_in,
  input  logic                     data_received,
  output logic                     rx_reset,
  output logic [16*CHANNELS-1:0]   ch_data,
  output logic                     frame_valid,
  output logic [IW-1:0]            word_index,
  output logic [7:0]               error_count
);
  typedef enum logic [1:0] {IDLE, RECEIVING, FLUSH_A, FLUSH_B} state_t;
  state_t state_q, state_d;
  logic [2:0] sync_q;
  logic [4:0] edge_cnt_q, edge_cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [IW-1:0] word_q, word_d;
  logic [7:0] err_q;
  logic [CHANNELS-1:0][15:0] shadow_q, ch_q;
  logic pub_q, fv_q, wr, err_inc, spi_edge;
  // sync_q[1:0] is the synchroniser, sync_q[2] the edge detector history
  assign spi_edge = sync_q[1] & ~sync_q[2];
  assign timer_d = (spi_edge || data_received) ? '0 :
                   (timer_q == TW'(FRAME_GAP)) ? timer_q : timer_q + 1'b1;
  always_comb begin
    state_d = state_q;
    edge_cnt_d = edge_cnt_q;
    word_d = word_q;
    wr = 1'b0;
    err_inc = 1'b0;
    case (state_q)
      IDLE:
        if (data_received) wr = 1'b1;
        else if (spi_edge) begin
          state_d = RECEIVING;
          edge_cnt_d = 5'd1;
        end else if (word_q != '0 && timer_q == TW'(FRAME_GAP)) begin
          word_d = '0;
          err_inc = 1'b1;
        end
      RECEIVING:
        if (data_received) begin
          wr = 1'b1;
          edge_cnt_d = '0;
          state_d = IDLE;
        end else if (spi_edge) edge_cnt_d = (edge_cnt_q == 5'd16) ? edge_cnt_q : edge_cnt_q + 5'd1;
        else if (timer_q == TW'(IDLE_CYCLES)) begin
          state_d = FLUSH_A;
          edge_cnt_d = '0;
        end
      FLUSH_A: state_d = FLUSH_B;
      FLUSH_B: begin
        state_d = IDLE;
        word_d = '0;
        err_inc = 1'b1;
      end
      default: state_d = IDLE;
    endcase
    if (wr) word_d = (word_q == IW'(CHANNELS - 1)) ? '0 : word_q + 1'b1;
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      sync_q <= '0;
      edge_cnt_q <= '0;
      timer_q <= '0;
      word_q <= '0;
      err_q <= '0;
      shadow_q <= '0;
      ch_q <= '0;
      pub_q <= 1'b0;
      fv_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sync_q <= {sync_q[1:0], spi_clock_in};
      edge_cnt_q <= edge_cnt_d;
      timer_q <= timer_d;
      word_q <= word_d;
      err_q <= (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;
      if (wr) shadow_q[word_q] <= data_in;
      // publish one cycle after the last slot lands so the whole frame moves at once
      pub_q <= wr && (word_q == IW'(CHANNELS - 1));
      fv_q <= pub_q;
      if (pub_q) ch_q <= shadow_q;
    end
  end
  assign rx_reset = (state_q == FLUSH_A) || (state_q == FLUSH_B);
  assign ch_data = ch_q;
  assign frame_valid = fv_q;
  assign word_index = word_q;
  assign error_count = err_q;
endmodule
